// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: command stage ahead of the PWM generator. Accepts
// direction/duty targets, slews duty_cycle toward the target one STEP per
// RAMP_DIV clocks, and on a direction change ramps to zero, holds a dead
// time, flips dir, then ramps back up. estop forces duty to zero at once.
module pwm_duty_ramp #(
    parameter int                  DIV_BITS = 16,
    parameter logic [DIV_BITS-1:0] RAMP_DIV = 16'd50000,
    parameter logic [6:0]          STEP     = 7'd1,
    parameter logic [DIV_BITS-1:0] DEADTIME = 16'd1000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [6:0] cmd_duty,
    input  logic       estop,
    output logic [6:0] duty_cycle,
    output logic       en,
    output logic       dir,
    output logic       busy,
    output logic       at_target
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP      = 2'd1,
        RAMP_DOWN = 2'd2,
        DEAD      = 2'd3
    } state_t;

    localparam logic [DIV_BITS-1:0] CNT_ONE   = {{(DIV_BITS-1){1'b0}}, 1'b1};
    localparam logic [DIV_BITS-1:0] CNT_ZERO  = '0;
    localparam logic [DIV_BITS-1:0] RAMP_LAST = RAMP_DIV - CNT_ONE;
    localparam logic [DIV_BITS-1:0] DEAD_LAST = DEADTIME - CNT_ONE;
    localparam logic [7:0]          MAX_DUTY  = 8'd100;

    // Smaller of two 8-bit magnitudes; limits a step so it never overshoots.
    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    // Saturate a requested duty to the 0..100 range.
    function automatic logic [6:0] clamp_duty(input logic [6:0] d);
        return ({1'b0, d} > MAX_DUTY) ? MAX_DUTY[6:0] : d;
    endfunction

    state_t              state_q, state_d;
    logic [6:0]          duty_q, duty_d;
    logic [6:0]          tgt_q, tgt_d;
    logic                dir_q, dir_d;
    logic                tdir_q, tdir_d;
    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic                at_target_q, at_target_d;

    logic [7:0] duty8, tgt8, step8, dist8, up_nxt8, dn_nxt8;
    logic [6:0] cmd_tgt;
    logic       tick;

    assign cmd_ready  = (state_q == IDLE) && !estop;
    assign duty_cycle = duty_q;
    assign en         = en_q;
    assign dir        = dir_q;
    assign busy       = busy_q;
    assign at_target  = at_target_q;

    // Step arithmetic toward the target, all compares and subtracts in 8 bits.
    always_comb begin
        duty8   = {1'b0, duty_q};
        tgt8    = {1'b0, tgt_q};
        step8   = {1'b0, STEP};
        dist8   = (tgt8 > duty8) ? (tgt8 - duty8) : (duty8 - tgt8);
        up_nxt8 = (tgt8 > duty8) ? (duty8 + min8(step8, dist8))
                                 : (duty8 - min8(step8, dist8));
        dn_nxt8 = duty8 - min8(step8, duty8);
        cmd_tgt = clamp_duty(cmd_duty);
        tick    = (cnt_q == RAMP_LAST);
    end

    // Next-state and next-output logic; estop overrides every state.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        dir_d   = dir_q;
        tdir_d  = tdir_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;

        if (estop) begin
            state_d = IDLE;
            duty_d  = 7'd0;
            tgt_d   = 7'd0;
            cnt_d   = CNT_ZERO;
            en_d    = (duty_q != 7'd0);
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        tgt_d  = cmd_tgt;
                        tdir_d = cmd_dir;
                        cnt_d  = CNT_ZERO;
                        if (cmd_dir == dir_q) begin
                            if (cmd_tgt != duty_q) state_d = RAMP;
                        end else if (duty_q != 7'd0) begin
                            state_d = RAMP_DOWN;
                        end else begin
                            state_d = DEAD;
                        end
                    end
                end
                RAMP: begin
                    if (duty_q == tgt_q) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        cnt_d  = CNT_ZERO;
                        duty_d = up_nxt8[6:0];
                        en_d   = 1'b1;
                        if (up_nxt8 == tgt8) state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RAMP_DOWN: begin
                    if (tick) begin
                        cnt_d  = CNT_ZERO;
                        duty_d = dn_nxt8[6:0];
                        en_d   = 1'b1;
                        if (dn_nxt8 == 8'd0) state_d = DEAD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DEAD: begin
                    if (cnt_q == DEAD_LAST) begin
                        cnt_d   = CNT_ZERO;
                        dir_d   = tdir_q;
                        state_d = (tgt_q != 7'd0) ? RAMP : IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d      = (state_d != IDLE);
        at_target_d = (state_d == IDLE);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            duty_q      <= 7'd0;
            tgt_q       <= 7'd0;
            dir_q       <= 1'b0;
            tdir_q      <= 1'b0;
            cnt_q       <= CNT_ZERO;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            tgt_q       <= tgt_d;
            dir_q       <= dir_d;
            tdir_q      <= tdir_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with RAMP_DIV=4, STEP=10, DEADTIME=3.
// A reference model queues every expected en pulse (cycle, duty, dir);
// a monitor pops and compares whenever en is seen or a pulse is due.
module tb_pwm_duty_ramp;

    localparam int RD = 4;
    localparam int ST = 10;
    localparam int DT = 3;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_dir = 1'b0;
    logic [6:0] cmd_duty = 7'd0;
    logic       estop = 1'b0;
    logic       cmd_ready, en, dir, busy, at_target;
    logic [6:0] duty_cycle;

    typedef struct {
        int   duty;
        logic dir;
        int   t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;
    int   en_count = 0;
    int   m_duty = 0;
    logic m_dir = 1'b0;
    logic exp_en;

    pwm_duty_ramp #(
        .DIV_BITS(16),
        .RAMP_DIV(16'd4),
        .STEP    (7'd10),
        .DEADTIME(16'd3)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_duty  (cmd_duty),
        .estop     (estop),
        .duty_cycle(duty_cycle),
        .en        (en),
        .dir       (dir),
        .busy      (busy),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (clr_n) begin
            exp_en = (q.size() > 0) && (q[0].t == cyc);
            if (en) en_count++;
            if (en || exp_en) begin
                check("en_pulse", en, exp_en);
                if (exp_en) begin
                    check("en_duty", duty_cycle, q[0].duty);
                    check("en_dir", dir, q[0].dir);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic push_exp(input int d, input logic dr, input int t);
        exp_t e;
        e.duty = d;
        e.dir  = dr;
        e.t    = t;
        q.push_back(e);
    endtask

    // Reference model: queue every step a command should produce.
    task automatic plan(input int req, input logic rdir, input int acc, output int t_end);
        int tgt, t, dl;
        tgt = (req > 100) ? 100 : req;
        t = acc;
        if (rdir != m_dir) begin
            while (m_duty != 0) begin
                t += RD;
                dl = (m_duty < ST) ? m_duty : ST;
                m_duty -= dl;
                push_exp(m_duty, m_dir, t);
            end
            t += DT;
            m_dir = rdir;
        end
        while (m_duty != tgt) begin
            t += RD;
            dl = (tgt > m_duty) ? (tgt - m_duty) : (m_duty - tgt);
            if (dl > ST) dl = ST;
            m_duty = (tgt > m_duty) ? (m_duty + dl) : (m_duty - dl);
            push_exp(m_duty, m_dir, t);
        end
        t_end = t;
    endtask

    task automatic send(input logic d, input int du, output int acc, output int waited);
        logic [31:0] duv;
        duv = du;
        step();
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_duty  = duv[6:0];
        waited = 0;
        while (!cmd_ready && waited < 200) begin
            step();
            waited++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        step();
        clr_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        step();
        clr_n  = 1'b1;
        m_duty = 0;
        m_dir  = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int d, input logic dr);
        check({tag, "_duty"}, duty_cycle, d);
        check({tag, "_dir"}, dir, dr);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_at_target"}, at_target, 1);
        check({tag, "_queue_empty"}, q.size(), 0);
    endtask

    initial begin
        int acc, te, w, en0;

        // Reset values
        repeat (3) @(posedge clk);
        step();
        check("rst_duty", duty_cycle, 0);
        check("rst_dir", dir, 0);
        check("rst_en", en, 0);
        check("rst_busy", busy, 0);
        check("rst_at_target", at_target, 1);
        check("rst_cmd_ready", cmd_ready, 1);
        step();
        clr_n = 1'b1;

        // 1: ramp up 0 -> 35
        send(1'b0, 35, acc, w);
        plan(35, 1'b0, acc, te);
        step();
        check("t1_busy", busy, 1);
        check("t1_at_target", at_target, 0);
        check("t1_cmd_ready", cmd_ready, 0);
        wait_until(te);
        idle_check("t1", 35, 1'b0);

        // 4: command equal to current state
        send(1'b0, 35, acc, w);
        plan(35, 1'b0, acc, te);
        check("t4_wait", w, 0);
        step();
        check("t4_en", en, 0);
        idle_check("t4", 35, 1'b0);

        // 2: direction change 35/dir0 -> 20/dir1
        send(1'b1, 20, acc, w);
        plan(20, 1'b1, acc, te);
        wait_until(acc + 18);
        check("t2_dead_duty", duty_cycle, 0);
        check("t2_dead_dir", dir, 0);
        check("t2_dead_busy", busy, 1);
        wait_until(acc + 19);
        check("t2_flip_dir", dir, 1);
        wait_until(te);
        idle_check("t2", 20, 1'b1);

        // 3: clamp 127 -> 100 from zero
        do_reset();
        en0 = en_count;
        send(1'b0, 127, acc, w);
        plan(127, 1'b0, acc, te);
        wait_until(te + 2);
        check("t3_pulses", en_count - en0, 10);
        idle_check("t3", 100, 1'b0);

        // 5: estop during ramp at duty 20, command held through it
        do_reset();
        send(1'b0, 50, acc, w);
        plan(50, 1'b0, acc, te);
        wait_until(acc + 8);
        check("t5_pre_duty", duty_cycle, 20);
        q.delete();
        estop = 1'b1;
        m_duty = 0;
        push_exp(0, 1'b0, acc + 9);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_duty  = 7'd30;
        #1;
        check("t5_ready_estop", cmd_ready, 0);
        step();
        check("t5_duty", duty_cycle, 0);
        check("t5_idle", at_target, 1);
        check("t5_busy", busy, 0);
        repeat (2) begin
            step();
            check("t5_ready_held", cmd_ready, 0);
        end
        estop = 1'b0;
        #1;
        check("t5_ready_release", cmd_ready, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
        plan(30, 1'b0, acc, te);
        step();
        check("t5_accepted", busy, 1);
        wait_until(te);
        idle_check("t5", 30, 1'b0);

        // 6: asynchronous clear while in DEAD
        send(1'b1, 30, acc, w);
        plan(30, 1'b1, acc, te);
        wait_until(acc + 13);
        check("t6_in_dead", busy, 1);
        clr_n = 1'b0;
        q.delete();
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_at_target", at_target, 1);
        check("t6_rst_duty", duty_cycle, 0);
        check("t6_rst_dir", dir, 0);
        check("t6_rst_en", en, 0);
        repeat (2) @(posedge clk);
        step();
        clr_n  = 1'b1;
        m_duty = 0;
        m_dir  = 1'b0;
        repeat (3) step();
        send(1'b1, 10, acc, w);
        plan(10, 1'b1, acc, te);
        step();
        check("t6_dead_dir", dir, 0);
        check("t6_dead_busy", busy, 1);
        wait_until(acc + 3);
        check("t6_flip_dir", dir, 1);
        check("t6_flip_duty", duty_cycle, 0);
        wait_until(te);
        idle_check("t6", 10, 1'b1);

        repeat (4) step();
        check("final_queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
